// File: rtl/framebuffer_stream_writer_pkg.sv
// Shared AXI encodings and FSM state type for the framebuffer stream writer.
package framebuffer_stream_writer_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } wr_state_t;

endpackage

// File: rtl/framebuffer_stream_writer_pixel_packer.sv
// Packs STREAM_WIDTH pixels into DATA_WIDTH beats (first pixel in the low lane) behind
// a single output register, so one beat can drain while the next one fills.
module framebuffer_stream_writer_pixel_packer #(
  parameter int STREAM_WIDTH = 16,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [STREAM_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data
);

  localparam int PPB    = DATA_WIDTH / STREAM_WIDTH;
  localparam int FILL_W = (PPB > 1) ? $clog2(PPB) : 1;

  logic [FILL_W-1:0]     fill;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] beat;
  logic                  last_slot;
  logic                  in_fire;

  // The closing pixel of a beat may only enter when the output register is free or draining.
  assign last_slot = (fill == FILL_W'(PPB - 1));
  assign in_ready  = !(last_slot && out_valid && !out_ready);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    beat = acc;
    beat[DATA_WIDTH-1 -: STREAM_WIDTH] = in_data;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      fill      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (in_fire) begin
        if (last_slot) begin
          out_data  <= beat;
          out_valid <= 1'b1;
          fill      <= '0;
        end else begin
          acc[fill*STREAM_WIDTH +: STREAM_WIDTH] <= in_data;
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/framebuffer_stream_writer.sv
// Writes fb_size pixels from an AXIS pixel stream to memory as aligned AXI4 INCR bursts,
// one burst outstanding at a time, and pulses done after the final write response.
module framebuffer_stream_writer
  import framebuffer_stream_writer_pkg::*;
#(
  parameter int STREAM_WIDTH        = 16,
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 32,
  parameter int STRB_WIDTH          = 4,
  parameter int ID_WIDTH            = 8,
  parameter int BURST_LEN           = 16,
  parameter int FB_SIZE_IN_PIXEL_LG = 20
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          fb_addr,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size,
  output logic                           busy,
  output logic                           done,
  output logic                           resp_error,
  output logic                           tlast_error,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0]        s_axis_tdata,
  output logic [ID_WIDTH-1:0]            m_mem_axi_awid,
  output logic [ADDR_WIDTH-1:0]          m_mem_axi_awaddr,
  output logic [7:0]                     m_mem_axi_awlen,
  output logic [2:0]                     m_mem_axi_awsize,
  output logic [1:0]                     m_mem_axi_awburst,
  output logic                           m_mem_axi_awlock,
  output logic [3:0]                     m_mem_axi_awcache,
  output logic [2:0]                     m_mem_axi_awprot,
  output logic                           m_mem_axi_awvalid,
  input  logic                           m_mem_axi_awready,
  output logic [DATA_WIDTH-1:0]          m_mem_axi_wdata,
  output logic [STRB_WIDTH-1:0]          m_mem_axi_wstrb,
  output logic                           m_mem_axi_wlast,
  output logic                           m_mem_axi_wvalid,
  input  logic                           m_mem_axi_wready,
  input  logic [ID_WIDTH-1:0]            m_mem_axi_bid,
  input  logic [1:0]                     m_mem_axi_bresp,
  input  logic                           m_mem_axi_bvalid,
  output logic                           m_mem_axi_bready
);

  localparam int FB_LG    = FB_SIZE_IN_PIXEL_LG;
  localparam int PPB      = DATA_WIDTH / STREAM_WIDTH;
  localparam int PPB_LG   = $clog2(PPB);
  localparam int STRB_LG  = $clog2(STRB_WIDTH);
  localparam int ADDR_LSB = $clog2(BURST_LEN * STRB_WIDTH);
  localparam int BL_W     = $clog2(BURST_LEN) + 1;
  localparam int PIX_W    = $clog2(BURST_LEN * PPB) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~ADDR_WIDTH'((1 << ADDR_LSB) - 1);

  wr_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [FB_LG-1:0]      beats_left;
  logic [FB_LG-1:0]      pix_total_left;
  logic [FB_LG-1:0]      start_beats;
  logic [BL_W-1:0]       burst_beats_q;
  logic [BL_W-1:0]       w_left;
  logic [BL_W-1:0]       cur_burst;
  logic [PIX_W-1:0]      pix_left;
  logic                  pix_gate;
  logic                  px_fire;
  logic                  w_fire;
  logic                  aw_fire;
  logic                  b_fire;
  logic                  pk_in_ready;
  logic                  pk_out_valid;
  logic [DATA_WIDTH-1:0] pk_out_data;
  logic                  unused_bid;

  assign unused_bid  = ^m_mem_axi_bid;
  assign start_beats = fb_size >> PPB_LG;
  assign cur_burst   = (beats_left > FB_LG'(BURST_LEN)) ? BL_W'(BURST_LEN) : BL_W'(beats_left);

  // Pixels are only admitted while the current burst still has room for them.
  assign pix_gate      = (state_q == ST_DATA) && (pix_left != '0);
  assign s_axis_tready = pix_gate && pk_in_ready;
  assign px_fire       = s_axis_tvalid && s_axis_tready;

  framebuffer_stream_writer_pixel_packer #(
    .STREAM_WIDTH (STREAM_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_pixel_packer (
    .aclk      (aclk),
    .resetn    (resetn),
    .in_valid  (s_axis_tvalid && pix_gate),
    .in_ready  (pk_in_ready),
    .in_data   (s_axis_tdata),
    .out_valid (pk_out_valid),
    .out_ready (m_mem_axi_wready && (state_q == ST_DATA)),
    .out_data  (pk_out_data)
  );

  assign m_mem_axi_awid    = '0;
  assign m_mem_axi_awaddr  = addr_q;
  assign m_mem_axi_awlen   = 8'(cur_burst - BL_W'(1));
  assign m_mem_axi_awsize  = 3'(STRB_LG);
  assign m_mem_axi_awburst = AXI_BURST_INCR;
  assign m_mem_axi_awlock  = 1'b0;
  assign m_mem_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_mem_axi_awprot  = 3'b000;
  assign m_mem_axi_wdata   = pk_out_data;
  assign m_mem_axi_wstrb   = '1;
  assign m_mem_axi_wvalid  = pk_out_valid && (state_q == ST_DATA);
  assign m_mem_axi_wlast   = m_mem_axi_wvalid && (w_left == BL_W'(1));

  assign aw_fire = m_mem_axi_awvalid && m_mem_axi_awready;
  assign w_fire  = m_mem_axi_wvalid && m_mem_axi_wready;
  assign b_fire  = m_mem_axi_bvalid && m_mem_axi_bready;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    m_mem_axi_awvalid = 1'b0;
    m_mem_axi_bready  = 1'b0;
    done              = 1'b0;
    busy              = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (start) state_d = (start_beats == '0) ? ST_DONE : ST_ADDR;
      ST_ADDR: begin
        m_mem_axi_awvalid = 1'b1;
        if (m_mem_axi_awready) state_d = ST_DATA;
      end
      ST_DATA: if (w_fire && m_mem_axi_wlast) state_d = ST_RESP;
      ST_RESP: begin
        m_mem_axi_bready = 1'b1;
        if (m_mem_axi_bvalid) state_d = (beats_left == '0) ? ST_DONE : ST_ADDR;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The pixel count, not tlast, decides where the frame ends; tlast only feeds the error flag.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      addr_q         <= '0;
      beats_left     <= '0;
      pix_total_left <= '0;
      burst_beats_q  <= '0;
      w_left         <= '0;
      pix_left       <= '0;
      resp_error     <= 1'b0;
      tlast_error    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          addr_q         <= fb_addr & ADDR_ALIGN_MASK;
          beats_left     <= start_beats;
          pix_total_left <= fb_size & ~FB_LG'(PPB - 1);
          resp_error     <= 1'b0;
          tlast_error    <= 1'b0;
        end
        ST_ADDR: if (aw_fire) begin
          burst_beats_q <= cur_burst;
          w_left        <= cur_burst;
          pix_left      <= PIX_W'(int'(cur_burst) * PPB);
          beats_left    <= beats_left - FB_LG'(cur_burst);
        end
        ST_DATA: begin
          if (px_fire) begin
            pix_left       <= pix_left - PIX_W'(1);
            pix_total_left <= pix_total_left - FB_LG'(1);
            if (s_axis_tlast != (pix_total_left == FB_LG'(1))) tlast_error <= 1'b1;
          end
          if (w_fire) w_left <= w_left - BL_W'(1);
        end
        ST_RESP: if (b_fire) begin
          if (m_mem_axi_bresp != AXI_RESP_OKAY) resp_error <= 1'b1;
          addr_q <= addr_q + (ADDR_WIDTH'(burst_beats_q) << STRB_LG);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_stream_writer.sv
// Directed bench for framebuffer_stream_writer: AXI memory slave and pixel ramp source with
// optional random stalls; results are compared against hand-computed expectations.
module tb_framebuffer_stream_writer;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] fb_addr;
  logic [19:0] fb_size;
  logic        busy, done, resp_error, tlast_error;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [15:0] s_axis_tdata;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 aclk = ~aclk;

  framebuffer_stream_writer dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .start             (start),
    .fb_addr           (fb_addr),
    .fb_size           (fb_size),
    .busy              (busy),
    .done              (done),
    .resp_error        (resp_error),
    .tlast_error       (tlast_error),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tdata      (s_axis_tdata),
    .m_mem_axi_awid    (awid),
    .m_mem_axi_awaddr  (awaddr),
    .m_mem_axi_awlen   (awlen),
    .m_mem_axi_awsize  (awsize),
    .m_mem_axi_awburst (awburst),
    .m_mem_axi_awlock  (awlock),
    .m_mem_axi_awcache (awcache),
    .m_mem_axi_awprot  (awprot),
    .m_mem_axi_awvalid (awvalid),
    .m_mem_axi_awready (awready),
    .m_mem_axi_wdata   (wdata),
    .m_mem_axi_wstrb   (wstrb),
    .m_mem_axi_wlast   (wlast),
    .m_mem_axi_wvalid  (wvalid),
    .m_mem_axi_wready  (wready),
    .m_mem_axi_bid     (bid),
    .m_mem_axi_bresp   (bresp),
    .m_mem_axi_bvalid  (bvalid),
    .m_mem_axi_bready  (bready)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mem [0:2047];
  int          npix = 0, pix_idx = 0, tlast_pos = 0, err_burst = -1;
  logic [15:0] pix_base = 16'h0;
  bit          stall_en = 1'b0;
  int          done_cnt, n_aw, n_w, n_b, n_wlast, wlast_bad, cur_len, burst_beat;
  logic [31:0] aw_addr_log [0:63];
  logic [7:0]  aw_len_log  [0:63];
  int          wlast_at    [0:63];
  logic [31:0] cur_addr;
  logic [2:0]  aw_size_seen;
  logic [1:0]  aw_burst_seen;
  logic [3:0]  aw_cache_seen;
  bit          b_pending, aw_fire, w_fire, b_fire, t_fire;
  logic        busy_after_start;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory slave and pixel source: sample handshakes at negedge, change drives just after posedge.
  initial begin : env
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    b_pending = 1'b0;
    forever begin
      @(negedge aclk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      t_fire  = s_axis_tvalid && s_axis_tready;
      if (resetn) begin
        if (done) done_cnt++;
        if (aw_fire) begin
          if (n_aw < 64) begin
            aw_addr_log[n_aw] = awaddr;
            aw_len_log[n_aw]  = awlen;
          end
          n_aw++;
          cur_addr = awaddr; cur_len = int'(awlen); burst_beat = 0;
          aw_size_seen = awsize; aw_burst_seen = awburst; aw_cache_seen = awcache;
        end
        if (w_fire) begin
          mem[cur_addr[12:2]] = wdata;
          cur_addr = cur_addr + 32'd4;
          n_w++;
          if (wlast != (burst_beat == cur_len)) wlast_bad++;
          if (wlast) begin
            if (n_wlast < 64) wlast_at[n_wlast] = n_w;
            n_wlast++;
            b_pending = 1'b1;
          end
          burst_beat++;
        end
        if (b_fire) n_b++;
        if (t_fire) pix_idx++;
      end
      @(posedge aclk);
      #1;
      if (!resetn) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; b_pending = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      end else begin
        awready = !stall_en || ($urandom_range(0, 2) != 0);
        wready  = !stall_en || ($urandom_range(0, 2) != 0);
        if (b_fire) bvalid = 1'b0;
        if (!bvalid && b_pending && (!stall_en || $urandom_range(0, 1) == 1)) begin
          bvalid    = 1'b1;
          bresp     = (n_b == err_burst) ? 2'b10 : 2'b00;
          b_pending = 1'b0;
        end
        if (!s_axis_tvalid || t_fire) begin
          if (pix_idx < npix && (!stall_en || $urandom_range(0, 3) != 0)) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pix_base + 16'(pix_idx);
            s_axis_tlast  = (pix_idx == tlast_pos);
          end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
          end
        end
      end
    end
  end

  task automatic setupEnv(input int size, input int tlast_idx, input bit stall, input int errb,
                          input logic [15:0] base);
    for (int i = 0; i < 2048; i++) mem[i] = 32'hDEADBEEF;
    done_cnt = 0; n_aw = 0; n_w = 0; n_b = 0; n_wlast = 0; wlast_bad = 0;
    b_pending = 1'b0; bvalid = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    npix = size; pix_idx = 0; tlast_pos = tlast_idx; stall_en = stall; err_burst = errb;
    pix_base = base;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input int size, input int tlast_idx,
                               input bit stall, input int errb, input logic [15:0] base);
    @(posedge aclk);
    #2;
    setupEnv(size, tlast_idx, stall, errb, base);
    start = 1'b1; fb_addr = addr; fb_size = 20'(size);
    @(posedge aclk);
    #2;
    start = 1'b0;
    busy_after_start = busy;
    for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
      @(negedge aclk);
      #1;
    end
    checkOutput("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (4) @(negedge aclk);
    #1;
  endtask

  task automatic checkMem(input int nbeats, input logic [15:0] base);
    int bad;
    logic [15:0] lo, hi;
    bad = 0;
    for (int k = 0; k < nbeats; k++) begin
      lo = base + 16'(2 * k);
      hi = lo + 16'd1;
      if (mem[1024 + k] !== {hi, lo}) bad++;
    end
    if (mem[1024 + nbeats] !== 32'hDEADBEEF) bad++;
    checkOutput("mem_image", 32'(bad), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    resetn = 1'b0; start = 1'b0; fb_addr = '0; fb_size = '0;
    repeat (3) @(posedge aclk);
    #2;
    checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("rst_aw_w_b", {28'd0, awvalid, wvalid, wlast, bready}, 32'd0);
    checkOutput("rst_tready_err", {29'd0, s_axis_tready, resp_error, tlast_error}, 32'd0);
    resetn = 1'b1;

    $display("[TB] two full bursts of 64 pixels");
    applyStimulus(32'h1000, 64, 63, 1'b0, -1, 16'h0000);
    checkOutput("t1_busy_start", 32'(busy_after_start), 32'd1);
    checkOutput("t1_n_aw", n_aw, 2);
    checkOutput("t1_aw0_addr", aw_addr_log[0], 32'h1000);
    checkOutput("t1_aw0_len", 32'(aw_len_log[0]), 32'd15);
    checkOutput("t1_aw1_addr", aw_addr_log[1], 32'h1040);
    checkOutput("t1_aw1_len", 32'(aw_len_log[1]), 32'd15);
    checkOutput("t1_aw_attr", {23'd0, aw_size_seen, aw_burst_seen, aw_cache_seen}, {23'd0, 3'd2, 2'b01, 4'b0011});
    checkOutput("t1_n_w", n_w, 32);
    checkOutput("t1_wlast_pos", wlast_bad, 0);
    checkOutput("t1_done_cnt", done_cnt, 1);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_errors", {30'd0, resp_error, tlast_error}, 32'd0);
    checkMem(32, 16'h0000);

    $display("[TB] 40 pixels, unaligned base forced down to 0x1000");
    applyStimulus(32'h1025, 40, 39, 1'b0, -1, 16'h0100);
    checkOutput("t2_n_aw", n_aw, 2);
    checkOutput("t2_aw0_addr", aw_addr_log[0], 32'h1000);
    checkOutput("t2_aw0_len", 32'(aw_len_log[0]), 32'd15);
    checkOutput("t2_aw1_addr", aw_addr_log[1], 32'h1040);
    checkOutput("t2_aw1_len", 32'(aw_len_log[1]), 32'd3);
    checkOutput("t2_wlast_a", wlast_at[0], 16);
    checkOutput("t2_wlast_b", wlast_at[1], 20);
    checkOutput("t2_done_cnt", done_cnt, 1);
    checkMem(20, 16'h0100);

    $display("[TB] 1000 pixels with random stalls on every channel");
    applyStimulus(32'h1000, 1000, 999, 1'b1, -1, 16'h2000);
    checkOutput("t3_n_aw", n_aw, 32);
    checkOutput("t3_last_addr", aw_addr_log[31], 32'h17C0);
    checkOutput("t3_last_len", 32'(aw_len_log[31]), 32'd3);
    checkOutput("t3_n_w", n_w, 500);
    checkOutput("t3_wlast_pos", wlast_bad, 0);
    checkOutput("t3_done_cnt", done_cnt, 1);
    checkOutput("t3_errors", {30'd0, resp_error, tlast_error}, 32'd0);
    checkMem(500, 16'h2000);

    $display("[TB] SLVERR on the second of three bursts");
    applyStimulus(32'h1000, 96, 95, 1'b1, 1, 16'h3000);
    checkOutput("t4_n_aw", n_aw, 3);
    checkOutput("t4_n_b", n_b, 3);
    checkOutput("t4_resp_error", 32'(resp_error), 32'd1);
    checkOutput("t4_done_cnt", done_cnt, 1);
    checkMem(48, 16'h3000);

    $display("[TB] early tlast on pixel 10 of 64");
    applyStimulus(32'h1000, 64, 9, 1'b0, -1, 16'h4000);
    checkOutput("t5_tlast_error", 32'(tlast_error), 32'd1);
    checkOutput("t5_resp_cleared", 32'(resp_error), 32'd0);
    checkOutput("t5_n_w", n_w, 32);
    checkMem(32, 16'h4000);

    $display("[TB] zero-length frame");
    applyStimulus(32'h1000, 0, -1, 1'b0, -1, 16'h0000);
    checkOutput("t6_busy_start", 32'(busy_after_start), 32'd1);
    checkOutput("t6_done_cnt", done_cnt, 1);
    checkOutput("t6_n_aw", n_aw, 0);
    checkOutput("t6_n_w", n_w, 0);

    $display("[TB] reset asserted in the middle of a data phase");
    @(posedge aclk);
    #2;
    setupEnv(64, 63, 1'b0, -1, 16'h5000);
    start = 1'b1; fb_addr = 32'h1000; fb_size = 20'd64;
    @(posedge aclk);
    #2;
    start = 1'b0;
    for (int c = 0; c < 200 && !wvalid; c++) begin
      @(negedge aclk);
    end
    checkOutput("t7_reached_data", 32'(wvalid), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("t7_rst_now", {28'd0, awvalid, wvalid, busy, s_axis_tready}, 32'd0);
    repeat (2) @(posedge aclk);
    #3;
    resetn = 1'b1;
    applyStimulus(32'h1000, 64, 63, 1'b0, -1, 16'h6000);
    checkOutput("t7_n_aw", n_aw, 2);
    checkOutput("t7_aw0_addr", aw_addr_log[0], 32'h1000);
    checkOutput("t7_done_cnt", done_cnt, 1);
    checkOutput("t7_errors", {30'd0, resp_error, tlast_error}, 32'd0);
    checkMem(32, 16'h6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
